bus_datapath: RTL and testbench

- Datapath responder for the beat-driven controller: it receives the controller's per-register strobes and carries them out on a shared internal data bus.
- Strobe families: register load (i*), bus drive (e*), RAM and program-counter strobes.
- Holds R0, R1, BP, SP, IR, MAR, the RAM address register (AR), PC and the ALU operand latch.
- Sits between the controller and a combinational-read data RAM; monitors bus contention for debug.

---
 rtl/bus_datapath.sv | 130 +++++++++++++
 tb/tb_bus_datapath.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/bus_datapath.sv
// Register/bus datapath driven by per-register strobes from the beat controller.
// Sources are OR-ed onto a shared bus; concurrent drivers are flagged and counted.
module bus_datapath #(
  parameter int             DW      = 16,
  parameter int             AW      = 16,
  parameter int             IMM_W   = 8,
  parameter logic [DW-1:0]  SP_INIT = 16'h0000,
  parameter int             CNT_W   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             idr_0,
  input  logic             idr_1,
  input  logic             idr_bp,
  input  logic             idr_sp,
  input  logic             edr_0,
  input  logic             edr_1,
  input  logic             edr_bp,
  input  logic             edr_sp,
  input  logic             iir,
  input  logic             eir,
  input  logic             imar,
  input  logic             emar,
  input  logic             iaddr,
  input  logic             iram,
  input  logic             eram,
  input  logic             ialu,
  input  logic             ealu,
  input  logic             ipc,
  input  logic             epc,
  input  logic [DW-1:0]    alu_result,
  input  logic [DW-1:0]    ram_rdata,
  output logic [AW-1:0]    ram_addr,
  output logic [DW-1:0]    ram_wdata,
  output logic             ram_we,
  output logic [DW-1:0]    ir,
  output logic [DW-1:0]    alu_opnd,
  output logic [DW-1:0]    bus,
  output logic [AW-1:0]    pc,
  output logic             bus_conflict,
  output logic [CNT_W-1:0] conflict_cnt
);

  logic [DW-1:0]    r0_q, r1_q, bp_q, sp_q, ir_q, mar_q, alu_q;
  logic [DW-1:0]    r0_d, r1_d, bp_d, sp_d, ir_d, mar_d, alu_d;
  logic [AW-1:0]    ar_q, ar_d, pc_q, pc_d;
  logic             conf_q, conf_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [DW-1:0]    bus_val;
  logic [DW-1:0]    imm_ext;
  logic [8:0]       src_en;
  logic             multi_src;
  logic             conflict_now;

  assign imm_ext = {{(DW-IMM_W){1'b0}}, ir_q[IMM_W-1:0]};
  assign src_en  = {edr_0, edr_1, edr_bp, edr_sp, eir, emar, eram, ealu, epc};
  // Clearing the lowest set bit leaves something only if two or more are set.
  assign multi_src    = |(src_en & (src_en - 9'd1));
  assign conflict_now = multi_src | (iram & iir);

  always_comb begin
    bus_val = '0;
    if (edr_0)  bus_val = bus_val | r0_q;
    if (edr_1)  bus_val = bus_val | r1_q;
    if (edr_bp) bus_val = bus_val | bp_q;
    if (edr_sp) bus_val = bus_val | sp_q;
    if (eir)    bus_val = bus_val | imm_ext;
    if (emar)   bus_val = bus_val | mar_q;
    if (eram)   bus_val = bus_val | ram_rdata;
    if (ealu)   bus_val = bus_val | alu_result;
    if (epc)    bus_val = bus_val | DW'(pc_q);
  end

  always_comb begin
    r0_d   = idr_0  ? bus_val : r0_q;
    r1_d   = idr_1  ? bus_val : r1_q;
    bp_d   = idr_bp ? bus_val : bp_q;
    sp_d   = idr_sp ? bus_val : sp_q;
    ir_d   = iir    ? ram_rdata : ir_q;
    mar_d  = imar   ? bus_val : mar_q;
    ar_d   = iaddr  ? AW'(bus_val) : ar_q;
    alu_d  = ialu   ? bus_val : alu_q;
    pc_d   = ipc    ? pc_q + {{(AW-1){1'b0}}, 1'b1} : pc_q;
    conf_d = conf_q | conflict_now;
    cnt_d  = cnt_q;
    if (conflict_now && (cnt_q != {CNT_W{1'b1}}))
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r0_q   <= '0;
      r1_q   <= '0;
      bp_q   <= '0;
      sp_q   <= SP_INIT;
      ir_q   <= '0;
      mar_q  <= '0;
      ar_q   <= '0;
      pc_q   <= '0;
      alu_q  <= '0;
      conf_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      r0_q   <= r0_d;
      r1_q   <= r1_d;
      bp_q   <= bp_d;
      sp_q   <= sp_d;
      ir_q   <= ir_d;
      mar_q  <= mar_d;
      ar_q   <= ar_d;
      pc_q   <= pc_d;
      alu_q  <= alu_d;
      conf_q <= conf_d;
      cnt_q  <= cnt_d;
    end
  end

  // Fetch owns the RAM port: address comes from PC and any store is dropped.
  assign ram_addr     = iir ? pc_q : ar_q;
  assign ram_wdata    = bus_val;
  assign ram_we       = iram & ~iir;
  assign bus          = bus_val;
  assign ir           = ir_q;
  assign alu_opnd     = alu_q;
  assign pc           = pc_q;
  assign bus_conflict = conf_q;
  assign conflict_cnt = cnt_q;

endmodule

// File: tb/tb_bus_datapath.sv
// Directed bench for bus_datapath: stimulus queues expected values, a negedge
// monitor pops and compares them against the DUT outputs.
module tb_bus_datapath;

  localparam int S_BUS = 0, S_IR = 1, S_PC = 2, S_ALU = 3, S_RADDR = 4,
                 S_WDATA = 5, S_WE = 6, S_CONF = 7, S_CNT = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        idr_0, idr_1, idr_bp, idr_sp, edr_0, edr_1, edr_bp, edr_sp;
  logic        iir, eir, imar, emar, iaddr, iram, eram, ialu, ealu, ipc, epc;
  logic [15:0] alu_result, ram_rdata, ram_addr, ram_wdata, ir, alu_opnd, bus, pc;
  logic        ram_we, bus_conflict;
  logic [7:0]  conflict_cnt;

  logic [15:0] mem [0:65535];

  typedef struct {
    int          sel;
    logic [31:0] val;
    string       name;
  } exp_t;
  exp_t exp_q[$];

  int checks = 0;
  int errors = 0;

  bus_datapath dut (
    .clk(clk), .reset(reset),
    .idr_0(idr_0), .idr_1(idr_1), .idr_bp(idr_bp), .idr_sp(idr_sp),
    .edr_0(edr_0), .edr_1(edr_1), .edr_bp(edr_bp), .edr_sp(edr_sp),
    .iir(iir), .eir(eir), .imar(imar), .emar(emar), .iaddr(iaddr),
    .iram(iram), .eram(eram), .ialu(ialu), .ealu(ealu), .ipc(ipc), .epc(epc),
    .alu_result(alu_result), .ram_rdata(ram_rdata), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_we(ram_we), .ir(ir), .alu_opnd(alu_opnd),
    .bus(bus), .pc(pc), .bus_conflict(bus_conflict), .conflict_cnt(conflict_cnt)
  );

  always #5 clk = ~clk;

  assign ram_rdata = mem[ram_addr];
  always @(posedge clk) if (ram_we) mem[ram_addr] = ram_wdata;

  function automatic logic [31:0] actual(input int sel);
    case (sel)
      S_BUS:   return {16'h0, bus};
      S_IR:    return {16'h0, ir};
      S_PC:    return {16'h0, pc};
      S_ALU:   return {16'h0, alu_opnd};
      S_RADDR: return {16'h0, ram_addr};
      S_WDATA: return {16'h0, ram_wdata};
      S_WE:    return {31'h0, ram_we};
      S_CONF:  return {31'h0, bus_conflict};
      default: return {24'h0, conflict_cnt};
    endcase
  endfunction

  always @(negedge clk) begin
    while (exp_q.size() > 0) begin
      exp_t e;
      logic [31:0] a;
      e = exp_q.pop_front();
      a = actual(e.sel);
      checks++;
      if (a !== e.val) begin
        errors++;
        $display("FAIL %s: got %h expected %h", e.name, a, e.val);
      end
    end
  end

  task automatic expect_val(input int sel, input logic [31:0] val, input string name);
    exp_t e;
    e.sel = sel; e.val = val; e.name = name;
    exp_q.push_back(e);
  endtask

  task automatic clr();
    {idr_0, idr_1, idr_bp, idr_sp, edr_0, edr_1, edr_bp, edr_sp} = '0;
    {iir, eir, imar, emar, iaddr, iram, eram, ialu, ealu, ipc, epc} = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 16'h0;
    mem[16'h0000] = 16'h0134;
    mem[16'h0034] = 16'hBEEF;
    alu_result = 16'h0;
    reset = 1'b0;
    {idr_0, idr_1, idr_bp, idr_sp, edr_0, edr_1, edr_bp, edr_sp} = '1;
    {iir, eir, imar, emar, iaddr, iram, eram, ialu, ealu, ipc, epc} = '1;

    // Reset with every strobe asserted
    step(); step();
    expect_val(S_IR, 0, "rst_ir");
    expect_val(S_PC, 0, "rst_pc");
    expect_val(S_ALU, 0, "rst_alu");
    expect_val(S_CONF, 0, "rst_conf");
    expect_val(S_CNT, 0, "rst_cnt");
    step();
    clr();
    reset = 1'b1;
    expect_val(S_BUS, 0, "idle_bus");
    step();
    edr_sp = 1'b1;
    expect_val(S_BUS, 0, "sp_init");
    step();

    // Fetch
    clr(); iir = 1'b1;
    expect_val(S_RADDR, 16'h0000, "fetch_addr");
    step();
    clr(); eir = 1'b1; imar = 1'b1;
    expect_val(S_IR, 16'h0134, "fetch_ir");
    expect_val(S_BUS, 16'h0034, "imm_bus");
    step();
    clr(); ipc = 1'b1;
    step();
    clr(); emar = 1'b1; iaddr = 1'b1;
    expect_val(S_BUS, 16'h0034, "mar_val");
    expect_val(S_PC, 16'h0001, "pc_inc");
    expect_val(S_CONF, 0, "fetch_noconf");
    step();

    // LD
    clr(); eram = 1'b1; idr_0 = 1'b1;
    expect_val(S_RADDR, 16'h0034, "ld_addr");
    expect_val(S_BUS, 16'hBEEF, "ld_bus");
    step();
    clr(); edr_0 = 1'b1;
    expect_val(S_BUS, 16'hBEEF, "ld_r0");
    step();

    // ST
    clr(); ealu = 1'b1; idr_1 = 1'b1; alu_result = 16'h1234;
    step();
    clr(); ealu = 1'b1; iaddr = 1'b1; alu_result = 16'h0050;
    step();
    clr(); iram = 1'b1; edr_1 = 1'b1;
    expect_val(S_WE, 1, "st_we");
    expect_val(S_WDATA, 16'h1234, "st_wdata");
    expect_val(S_RADDR, 16'h0050, "st_addr");
    step();
    clr(); eram = 1'b1;
    expect_val(S_WE, 0, "st_we_drop");
    expect_val(S_BUS, 16'h1234, "st_readback");
    expect_val(S_CONF, 0, "st_noconf");
    expect_val(S_CNT, 0, "st_nocnt");
    step();
    clr(); iram = 1'b1; edr_1 = 1'b1; iir = 1'b1;
    expect_val(S_WE, 0, "st_fetch_we");
    expect_val(S_RADDR, 16'h0001, "st_fetch_addr");
    step();
    clr(); eram = 1'b1;
    expect_val(S_CONF, 1, "st_fetch_conf");
    expect_val(S_CNT, 1, "st_fetch_cnt");
    expect_val(S_BUS, 16'h1234, "st_fetch_nowrite");
    step();

    // Mid-operation reset
    clr(); ipc = 1'b1; idr_0 = 1'b1; ealu = 1'b1;
    #2 reset = 1'b0;
    step();
    expect_val(S_CONF, 0, "rst2_conf");
    expect_val(S_CNT, 0, "rst2_cnt");
    expect_val(S_PC, 0, "rst2_pc");
    step();
    clr(); reset = 1'b1;
    step();

    // Contention
    clr(); ealu = 1'b1; idr_0 = 1'b1; alu_result = 16'h00F0;
    step();
    clr(); ealu = 1'b1; idr_bp = 1'b1; alu_result = 16'h0F00;
    step();
    clr(); edr_0 = 1'b1; edr_bp = 1'b1; idr_sp = 1'b1;
    expect_val(S_BUS, 16'h0FF0, "conf_bus");
    step();
    clr(); edr_sp = 1'b1;
    expect_val(S_BUS, 16'h0FF0, "conf_sp");
    expect_val(S_CONF, 1, "conf_flag");
    expect_val(S_CNT, 1, "conf_cnt1");
    step();
    clr(); edr_0 = 1'b1; edr_bp = 1'b1;
    repeat (253) step();
    expect_val(S_CNT, 8'hFE, "conf_cnt_fe");
    repeat (47) step();
    clr();
    expect_val(S_CNT, 8'hFF, "conf_cnt_sat");
    step();
    expect_val(S_CNT, 8'hFF, "conf_cnt_hold");
    expect_val(S_CONF, 1, "conf_sticky");
    step();

    // PC wrap and ALU latch
    clr(); ipc = 1'b1;
    repeat (65535) step();
    expect_val(S_PC, 16'hFFFF, "pc_max");
    step();
    clr(); epc = 1'b1; ipc = 1'b1;
    expect_val(S_PC, 16'h0000, "pc_wrap");
    expect_val(S_BUS, 16'h0000, "epc_old");
    step();
    clr(); ealu = 1'b1; ialu = 1'b1; alu_result = 16'h5A5A;
    expect_val(S_PC, 16'h0001, "pc_after_wrap");
    expect_val(S_BUS, 16'h5A5A, "alu_bus");
    step();
    clr();
    expect_val(S_ALU, 16'h5A5A, "alu_latch");
    step();
    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
